triangle_feeder: RTL

- Transmit side of the triangle handshake into the rasterizer.
- On each frame start, fetches NUM_TRIS triangles from an external mesh ROM (fixed read latency), presents each on vert1_out/vert2_out/vert3_out with valid_tri_out, and waits for ready_in.
- Flags the last triangle of the object with obj_done_out so the rasterizer swaps frame buffers.
- Sits between the mesh/transform memory and the rasterizer.

---
 rtl/triangle_feeder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/triangle_feeder.sv
// triangle_feeder: transmit side of the triangle handshake into the rasterizer.
// On each frame request it reads NUM_TRIS triangles from a fixed-latency mesh ROM.
// Each triangle is offered on vert1_out/vert2_out/vert3_out with valid_tri_out, and
// the block waits for ready_in. The last triangle is flagged with obj_done_out.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous, active-low reset
//   new_frame_in    one-cycle pulse requesting an object pass (one-deep pending queue)
//   mesh_addr_out   mesh ROM address (triangle index)
//   mesh_data_in    ROM word {v1,v2,v3}, each vertex {x,y,z}, v1 in the MSBs
//   vert1/2/3_out   captured vertices, [2]=x [1]=y [0]=z
//   valid_tri_out   triangle on vert*_out is valid
//   obj_done_out    current triangle is the object's last
//   ready_in        rasterizer can accept a triangle
//   busy_out        object pass in progress
//   frame_done_out  one-cycle pulse after the last triangle is accepted
//   tri_count_out   triangles accepted in the current pass
//
// Optional feature: define BACKFACE_CULL_EN to drop triangles with non-positive signed
// area. This adds one cycle per triangle, and the last triangle is always offered.
module triangle_feeder #(
    parameter int unsigned NUM_TRIS = 12,
    parameter int unsigned COORD_W  = 9,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   new_frame_in,
    output logic [ADDR_W-1:0]      mesh_addr_out,
    input  logic [9*COORD_W-1:0]   mesh_data_in,
    output logic [COORD_W-1:0]     vert1_out [2:0],
    output logic [COORD_W-1:0]     vert2_out [2:0],
    output logic [COORD_W-1:0]     vert3_out [2:0],
    output logic                   valid_tri_out,
    output logic                   obj_done_out,
    input  logic                   ready_in,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic [ADDR_W-1:0]      tri_count_out
);

    localparam int unsigned       CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_TRIS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StOffer = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
`ifdef BACKFACE_CULL_EN
    localparam logic [2:0] StCull  = 3'd5;
`endif

    logic [2:0]           state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 busy_q, busy_d;
    logic [ADDR_W-1:0]    count_q, count_d;
    logic [9*COORD_W-1:0] tri_q, tri_d;
    logic                 last_tri;

    assign last_tri = (idx_q == LAST_IDX);

`ifdef BACKFACE_CULL_EN
    localparam int unsigned AREA_W = 2*COORD_W + 2;

    logic signed [AREA_W-1:0] area_q, area_d;
    logic signed [AREA_W-1:0] dx2, dy2, dx3, dy3;
    logic                     area_pos;

    // Coordinates are unsigned screen positions; zero-extend before differencing.
    function automatic logic signed [AREA_W-1:0] ext(input logic [COORD_W-1:0] v);
        return $signed({{(AREA_W-COORD_W){1'b0}}, v});
    endfunction

    // Area is taken straight from the ROM word so it is registered alongside the capture.
    always_comb begin
        dx2    = ext(mesh_data_in[5*COORD_W +: COORD_W]) - ext(mesh_data_in[8*COORD_W +: COORD_W]);
        dy2    = ext(mesh_data_in[4*COORD_W +: COORD_W]) - ext(mesh_data_in[7*COORD_W +: COORD_W]);
        dx3    = ext(mesh_data_in[2*COORD_W +: COORD_W]) - ext(mesh_data_in[8*COORD_W +: COORD_W]);
        dy3    = ext(mesh_data_in[1*COORD_W +: COORD_W]) - ext(mesh_data_in[7*COORD_W +: COORD_W]);
        area_d = dx2 * dy3 - dx3 * dy2;
    end

    assign area_pos = !area_q[AREA_W-1] && (area_q != '0);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        count_d   = count_q;
        tri_d     = tri_q;
        // Requests during a pass (DONE included) collapse into a single pending pass.
        pending_d = pending_q | (new_frame_in & busy_q);
        case (state_q)
            StIdle: begin
                if (new_frame_in || pending_q) begin
                    idx_d     = '0;
                    pending_d = 1'b0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                cnt_d   = WAIT_LOAD;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    tri_d   = mesh_data_in;
`ifdef BACKFACE_CULL_EN
                    state_d = StCull;
`else
                    state_d = StOffer;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef BACKFACE_CULL_EN
            StCull: begin
                if (!area_pos && !last_tri) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StOffer;
                end
            end
`endif
            StOffer: begin
                if (ready_in) begin
                    count_d = count_q + 1'b1;
                    if (last_tri) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            tri_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            tri_q     <= tri_d;
        end
    end

`ifdef BACKFACE_CULL_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            area_q <= '0;
        end else if (state_q == StWait && cnt_q == '0) begin
            area_q <= area_d;
        end
    end
`endif

    // Outputs decode registered state only, so nothing depends combinationally on ready_in.
    assign mesh_addr_out  = idx_q;
    assign valid_tri_out  = (state_q == StOffer);
    assign obj_done_out   = (state_q == StOffer) && last_tri;
    assign busy_out       = busy_q;
    assign frame_done_out = (state_q == StDone);
    assign tri_count_out  = count_q;

    for (genvar c = 0; c < 3; c++) begin : g_vert
        assign vert1_out[c] = tri_q[(6 + c)*COORD_W +: COORD_W];
        assign vert2_out[c] = tri_q[(3 + c)*COORD_W +: COORD_W];
        assign vert3_out[c] = tri_q[c*COORD_W +: COORD_W];
    end

endmodule
